// File: rtl/pc_branch_sequencer.sv
// Program counter owner for the 5-stage pipeline: resolves BEQ/BNE/J in ID and redirects fetch.
// Latency: a branch resolved in cycle T has its target on pc at T+1; pc_plus4 is combinational.
// Backpressure: stall holds pc and defers resolution; during the flush window stall and br_valid are ignored.
module pc_branch_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [1:0]       br_type,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic [15:0]      imm16,
    input  logic [25:0]      jidx,
    input  logic [31:0]      id_pc4,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             if_id_flush,
    output logic             redirect,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [1:0] BT_BEQ = 2'b01;
    localparam logic [1:0] BT_BNE = 2'b10;
    localparam logic [1:0] BT_J   = 2'b11;

    // Flush window length minus one; two bits cover the legal 1..3 range.
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [1:0]  flush_cnt;
    logic [31:0] btarget;
    logic [31:0] jtarget;
    logic        taken;
    logic        resolve;

    assign pc_plus4 = pc + 32'd4;

    // Branch target adder and jump target concatenation, both mod 2^32.
    assign btarget = id_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign jtarget = {id_pc4[31:28], jidx, 2'b00};

    // Taken condition per control-flow type; type 00 is never a branch.
    always_comb begin
        taken = 1'b0;
        case (br_type)
            BT_BEQ:  taken = (rs_val == rt_val);
            BT_BNE:  taken = (rs_val != rt_val);
            BT_J:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign resolve = (state == RUN) && !stall && br_valid && (br_type != 2'b00);

    // Sequencer FSM: pc update, flush window, redirect pulse and saturating statistics.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            state        <= RUN;
            flush_cnt    <= 2'd0;
            if_id_flush  <= 1'b0;
            redirect     <= 1'b0;
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            case (state)
                RUN: begin
                    redirect    <= 1'b0;
                    if_id_flush <= 1'b0;
                    if (stall) begin
                        pc <= pc;
                    end else if (resolve) begin
                        if (branch_count != '1) begin
                            branch_count <= branch_count + CNT_W'(1);
                        end
                        if (taken) begin
                            pc          <= (br_type == BT_J) ? jtarget : btarget;
                            state       <= FLUSH;
                            flush_cnt   <= FLUSH_LOAD;
                            redirect    <= 1'b1;
                            if_id_flush <= 1'b1;
                            if (taken_count != '1) begin
                                taken_count <= taken_count + CNT_W'(1);
                            end
                        end else begin
                            pc <= pc_plus4;
                        end
                    end else begin
                        pc <= pc_plus4;
                    end
                end
                FLUSH: begin
                    // The ID instruction is being squashed, so nothing resolves here.
                    pc       <= pc_plus4;
                    redirect <= 1'b0;
                    if (flush_cnt == 2'd0) begin
                        state       <= RUN;
                        if_id_flush <= 1'b0;
                    end else begin
                        flush_cnt   <= flush_cnt - 2'd1;
                        if_id_flush <= 1'b1;
                    end
                end
                default: begin
                    state       <= RUN;
                    if_id_flush <= 1'b0;
                    redirect    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_branch_sequencer.sv
module tb_pc_branch_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_valid;
    logic [1:0]  br_type;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic [31:0] id_pc4;

    logic [31:0] pc, pc_plus4;
    logic        if_id_flush, redirect;
    logic [15:0] branch_count, taken_count;

    logic [31:0] pc3, pc_plus4_3;
    logic        flush3, redirect3;
    logic [15:0] bcnt3, tcnt3;

    logic [31:0] pcs, pc_plus4_s;
    logic        flushs, redirects;
    logic [1:0]  bcnts, tcnts;

    int checks;
    int failures;

    pc_branch_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_type(br_type),
        .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16), .jidx(jidx), .id_pc4(id_pc4),
        .pc(pc), .pc_plus4(pc_plus4), .if_id_flush(if_id_flush), .redirect(redirect),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    pc_branch_sequencer #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_type(br_type),
        .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16), .jidx(jidx), .id_pc4(id_pc4),
        .pc(pc3), .pc_plus4(pc_plus4_3), .if_id_flush(flush3), .redirect(redirect3),
        .branch_count(bcnt3), .taken_count(tcnt3)
    );

    pc_branch_sequencer #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_type(br_type),
        .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16), .jidx(jidx), .id_pc4(id_pc4),
        .pc(pcs), .pc_plus4(pc_plus4_s), .if_id_flush(flushs), .redirect(redirects),
        .branch_count(bcnts), .taken_count(tcnts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; br_valid = 0; br_type = 2'b00;
        rs_val = 0; rt_val = 0; imm16 = 0; jidx = 0; id_pc4 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc); end
        checks++; if (if_id_flush !== 1'b0 || redirect !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b%b exp=00", if_id_flush, redirect); end
        checks++; if (branch_count !== 16'd0 || taken_count !== 16'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", branch_count, taken_count); end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (pc !== 32'(i * 4) || if_id_flush !== 1'b0) begin failures++; $display("FAIL free_run_%0d got pc=%h flush=%b exp pc=%h flush=0", i, pc, if_id_flush, 32'(i * 4)); end
        end
        checks++; if (branch_count !== 16'd0 || taken_count !== 16'd0) begin failures++; $display("FAIL free_run_counts got=%0d/%0d exp=0/0", branch_count, taken_count); end
    endtask

    task automatic test_beq_taken();
        do_reset();
        br_valid = 1; br_type = 2'b01; rs_val = 5; rt_val = 5; id_pc4 = 32'h10; imm16 = 16'h0003;
        step();
        idle_inputs();
        checks++; if (pc !== 32'h1C) begin failures++; $display("FAIL beq_target got=%h exp=0000001c", pc); end
        checks++; if (redirect !== 1'b1 || if_id_flush !== 1'b1) begin failures++; $display("FAIL beq_redirect got=%b%b exp=11", redirect, if_id_flush); end
        checks++; if (branch_count !== 16'd1 || taken_count !== 16'd1) begin failures++; $display("FAIL beq_counts got=%0d/%0d exp=1/1", branch_count, taken_count); end
        step();
        checks++; if (pc !== 32'h20 || redirect !== 1'b0 || if_id_flush !== 1'b0) begin failures++; $display("FAIL beq_after got pc=%h rd=%b fl=%b exp 00000020 0 0", pc, redirect, if_id_flush); end
    endtask

    task automatic test_bne();
        do_reset();
        br_valid = 1; br_type = 2'b10; rs_val = 7; rt_val = 7; id_pc4 = 32'h100; imm16 = 16'h0010;
        step();
        checks++; if (pc !== 32'h4 || redirect !== 1'b0 || if_id_flush !== 1'b0) begin failures++; $display("FAIL bne_nt got pc=%h rd=%b fl=%b exp 00000004 0 0", pc, redirect, if_id_flush); end
        checks++; if (branch_count !== 16'd1 || taken_count !== 16'd0) begin failures++; $display("FAIL bne_nt_counts got=%0d/%0d exp=1/0", branch_count, taken_count); end
        rs_val = 1; rt_val = 2; id_pc4 = 32'h20; imm16 = 16'hFFFE;
        step();
        idle_inputs();
        checks++; if (pc !== 32'h18 || redirect !== 1'b1) begin failures++; $display("FAIL bne_taken got pc=%h rd=%b exp 00000018 1", pc, redirect); end
        checks++; if (branch_count !== 16'd2 || taken_count !== 16'd1) begin failures++; $display("FAIL bne_counts got=%0d/%0d exp=2/1", branch_count, taken_count); end
        // br_type 00 with br_valid is not a branch
        step();
        br_valid = 1; br_type = 2'b00; rs_val = 3; rt_val = 3;
        step();
        idle_inputs();
        checks++; if (pc !== 32'h20 || branch_count !== 16'd2 || redirect !== 1'b0) begin failures++; $display("FAIL type00 got pc=%h bc=%0d rd=%b exp 00000020 2 0", pc, branch_count, redirect); end
    endtask

    task automatic test_jump_wrap();
        do_reset();
        br_valid = 1; br_type = 2'b11; id_pc4 = 32'hA000_0008; jidx = 26'h0000040;
        step();
        idle_inputs();
        checks++; if (pc !== 32'hA000_0100) begin failures++; $display("FAIL jump_target got=%h exp=a0000100", pc); end
        step();
        br_valid = 1; br_type = 2'b01; rs_val = 9; rt_val = 9; id_pc4 = 32'hFFFF_FFFC; imm16 = 16'h0001;
        step();
        idle_inputs();
        checks++; if (pc !== 32'h0 || pc_plus4 !== 32'h4) begin failures++; $display("FAIL target_wrap got pc=%h p4=%h exp 00000000 00000004", pc, pc_plus4); end
        step();
        br_valid = 1; br_type = 2'b01; id_pc4 = 32'h0; imm16 = 16'hFFFF;
        step();
        idle_inputs();
        checks++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin failures++; $display("FAIL pc4_wrap got pc=%h p4=%h exp fffffffc 00000000", pc, pc_plus4); end
        step();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL pc_wrap got=%h exp=0", pc); end
        checks++; if (branch_count !== 16'd3 || taken_count !== 16'd3) begin failures++; $display("FAIL jump_counts got=%0d/%0d exp=3/3", branch_count, taken_count); end
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1; br_valid = 1; br_type = 2'b01; rs_val = 4; rt_val = 4; id_pc4 = 32'h100; imm16 = 16'h0004;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (pc !== 32'h0 || branch_count !== 16'd0 || taken_count !== 16'd0 || if_id_flush !== 1'b0) begin failures++; $display("FAIL stall_%0d got pc=%h bc=%0d tc=%0d fl=%b exp 0 0 0 0", i, pc, branch_count, taken_count, if_id_flush); end
        end
        stall = 0;
        step();
        idle_inputs();
        checks++; if (pc !== 32'h110 || redirect !== 1'b1 || taken_count !== 16'd1) begin failures++; $display("FAIL stall_release got pc=%h rd=%b tc=%0d exp 00000110 1 1", pc, redirect, taken_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        br_valid = 1; br_type = 2'b11; id_pc4 = 32'h0; jidx = 26'h10;
        step();
        checks++; if (pc3 !== 32'h40 || flush3 !== 1'b1 || redirect3 !== 1'b1) begin failures++; $display("FAIL f3_first got pc=%h fl=%b rd=%b exp 00000040 1 1", pc3, flush3, redirect3); end
        br_type = 2'b01; rs_val = 1; rt_val = 1; id_pc4 = 32'h200; imm16 = 16'h0000;
        step();
        checks++; if (pc3 !== 32'h44 || flush3 !== 1'b1 || redirect3 !== 1'b0) begin failures++; $display("FAIL f3_second got pc=%h fl=%b rd=%b exp 00000044 1 0", pc3, flush3, redirect3); end
        step();
        checks++; if (pc3 !== 32'h48 || flush3 !== 1'b1) begin failures++; $display("FAIL f3_third got pc=%h fl=%b exp 00000048 1", pc3, flush3); end
        step();
        checks++; if (pc3 !== 32'h4C || flush3 !== 1'b0 || bcnt3 !== 16'd1 || tcnt3 !== 16'd1) begin failures++; $display("FAIL f3_end got pc=%h fl=%b bc=%0d tc=%0d exp 0000004c 0 1 1", pc3, flush3, bcnt3, tcnt3); end
        step();
        idle_inputs();
        checks++; if (pc3 !== 32'h200 || redirect3 !== 1'b1 || bcnt3 !== 16'd2) begin failures++; $display("FAIL f3_first_run got pc=%h rd=%b bc=%0d exp 00000200 1 2", pc3, redirect3, bcnt3); end
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        br_valid = 1; br_type = 2'b11; id_pc4 = 32'h0; jidx = 26'h20;
        step();
        idle_inputs();
        step();
        checks++; if (flush3 !== 1'b1 || pc3 !== 32'h84) begin failures++; $display("FAIL rif_pre got fl=%b pc=%h exp 1 00000084", flush3, pc3); end
        reset = 1;
        step();
        reset = 0;
        checks++; if (pc3 !== 32'h0 || flush3 !== 1'b0 || redirect3 !== 1'b0 || bcnt3 !== 16'd0 || tcnt3 !== 16'd0) begin failures++; $display("FAIL rif_reset got pc=%h fl=%b rd=%b bc=%0d tc=%0d exp 0 0 0 0 0", pc3, flush3, redirect3, bcnt3, tcnt3); end
        step();
        checks++; if (pc3 !== 32'h4 || flush3 !== 1'b0) begin failures++; $display("FAIL rif_run got pc=%h fl=%b exp 00000004 0", pc3, flush3); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            br_valid = 1; br_type = 2'b11; id_pc4 = 32'h0; jidx = 26'(i + 1);
            step();
            idle_inputs();
            step();
        end
        checks++; if (bcnts !== 2'd3 || tcnts !== 2'd3) begin failures++; $display("FAIL sat_taken got=%0d/%0d exp=3/3", bcnts, tcnts); end
        br_valid = 1; br_type = 2'b01; rs_val = 1; rt_val = 2;
        step();
        idle_inputs();
        checks++; if (bcnts !== 2'd3 || tcnts !== 2'd3) begin failures++; $display("FAIL sat_hold got=%0d/%0d exp=3/3", bcnts, tcnts); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1;
        idle_inputs();
        test_reset();
        test_beq_taken();
        test_bne();
        test_jump_wrap();
        test_stall();
        test_back_to_back();
        test_reset_in_flush();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
